// File: rtl/pixel_sink_fifo.sv
// pixel_sink_fifo: buffers pixels from the decoder and releases one per
// display pixel enable across a fixed-length active line. Starved requests
// emit black pixels and latch a sticky underflow flag.
module pixel_sink_fifo #(
  parameter int DEPTH      = 16,
  parameter int LINE_WIDTH = 384
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_write,
  input  logic [7:0]               in_pixel,
  output logic                     in_strobe,
  input  logic                     pix_en,
  input  logic                     line_start,
  output logic [7:0]               out_pixel,
  output logic                     out_valid,
  output logic                     underflow,
  input  logic                     clear_underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  localparam logic [11:0] LAST_COL = 12'(LINE_WIDTH - 1);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          state_reg;
  logic          state_next;
  logic [11:0]   col_reg;
  logic [11:0]   col_next;
  logic [11:0]   col_cur;
  logic [7:0]    out_pixel_reg;
  logic          out_valid_reg;
  logic          underflow_reg;

  logic full;
  logic empty;
  logic push;
  logic service;
  logic pop;

  // Full/empty come from the registered level, so a pop never frees room
  // for a push in the same cycle.
  assign full    = (level_reg == FULL_LEVEL);
  assign empty   = (level_reg == '0);
  assign push    = in_write & ~full & ~reset;
  assign service = (state_reg == ST_ACTIVE) & pix_en;
  assign pop     = service & ~empty;

  // A line_start coinciding with a pixel enable makes that pixel column 0.
  assign col_cur = line_start ? 12'd0 : col_reg;

  assign in_strobe = push;
  assign out_pixel = out_pixel_reg;
  assign out_valid = out_valid_reg;
  assign underflow = underflow_reg;
  assign level     = level_reg;

  // Line sequencing: count serviced pixels, drop to idle after the last one.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    if (service) begin
      if (col_cur == LAST_COL) begin
        state_next = ST_IDLE;
        col_next   = 12'd0;
      end else begin
        col_next = col_cur + 12'd1;
      end
    end else if (line_start) begin
      state_next = ST_ACTIVE;
      col_next   = 12'd0;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_pixel;
    end
  end

  // Pointers, occupancy and line state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      state_reg  <= ST_IDLE;
      col_reg    <= 12'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      state_reg <= state_next;
      col_reg   <= col_next;
    end
  end

  // Output pixel register: popped data, or black when starved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pixel_reg <= 8'h00;
      out_valid_reg <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      out_valid_reg <= service;
      if (service) begin
        out_pixel_reg <= pop ? mem[rd_ptr_reg] : 8'h00;
      end
      if (service && empty) begin
        underflow_reg <= 1'b1;
      end else if (clear_underflow) begin
        underflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_sink_fifo.sv
// Testbench for pixel_sink_fifo: queue-based reference model, scoreboard
// monitor on the falling edge, directed scenarios then random traffic.
module tb_pixel_sink_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_write = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       in_strobe;
  logic       pix_en = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       underflow;
  logic       clear_underflow = 1'b0;
  logic [4:0] level;

  pixel_sink_fifo #(.DEPTH(DEPTH), .LINE_WIDTH(LW)) dut (
    .clk(clk),
    .reset(reset),
    .in_write(in_write),
    .in_pixel(in_pixel),
    .in_strobe(in_strobe),
    .pix_en(pix_en),
    .line_start(line_start),
    .out_pixel(out_pixel),
    .out_valid(out_valid),
    .underflow(underflow),
    .clear_underflow(clear_underflow),
    .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  byte unsigned m_q[$];
  byte unsigned exp_q[$];
  byte unsigned src_q[$];
  byte unsigned seen_q[$];
  bit  m_active = 1'b0;
  int  m_col = 0;
  bit  m_under = 1'b0;
  bit  acc_last = 1'b0;
  int  vcount = 0;
  int  scount = 0;
  bit  m_svc;
  bit  m_acc;
  int  m_c;
  int  m_sz;
  byte unsigned mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, line as an active flag plus column count.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_active = 1'b0;
      m_col    = 0;
      m_under  = 1'b0;
      acc_last = 1'b0;
    end else begin
      m_sz  = m_q.size();
      m_svc = m_active && pix_en;
      m_c   = line_start ? 0 : m_col;
      m_acc = in_write && (m_sz < DEPTH);
      if (m_svc) begin
        if (m_sz > 0) begin
          exp_q.push_back(m_q.pop_front());
        end else begin
          exp_q.push_back(8'h00);
        end
      end
      if (m_svc && m_sz == 0) m_under = 1'b1;
      else if (clear_underflow) m_under = 1'b0;
      if (m_acc) m_q.push_back(in_pixel);
      if (m_svc) begin
        if (m_c == LW - 1) begin
          m_active = 1'b0;
          m_col    = 0;
        end else begin
          m_col = m_c + 1;
        end
      end else if (line_start) begin
        m_active = 1'b1;
        m_col    = 0;
      end
      acc_last = m_acc;
    end
  end

  // Monitor/scoreboard on the falling edge.
  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), (exp_q.size() != 0) ? 1 : 0);
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      if (out_valid) chk("out_pixel", int'(out_pixel), int'(mon_e));
    end
    if (out_valid) begin
      vcount++;
      seen_q.push_back(out_pixel);
    end
    chk("underflow", int'(underflow), int'(m_under));
    chk("level", int'(level), m_q.size());
    chk("in_strobe", int'(in_strobe), (in_write && !reset && m_q.size() < DEPTH) ? 1 : 0);
    if (in_strobe) scount++;
  end

  // One clock of stimulus: inputs change 1 time unit after the rising edge.
  task automatic tick(input bit le, input bit pe, input bit cu);
    @(posedge clk);
    #1;
    if (acc_last && src_q.size() > 0) void'(src_q.pop_front());
    in_write        = (src_q.size() > 0);
    in_pixel        = in_write ? src_q[0] : 8'($urandom);
    line_start      = le;
    pix_en          = pe;
    clear_underflow = cu;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_line(input int n);
    tick(1'b1, 1'b0, 1'b0);
    repeat (n) tick(1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && (m_q.size() > 0 || src_q.size() > 0); k++) run_line(LW);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  int sbase;
  int vbase;
  bit rst_pending;

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);
    chk("reset_level", int'(level), 0);
    chk("reset_out_valid", int'(out_valid), 0);

    // Four pixels in, one line out in order.
    sbase = scount;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h10 + i));
    idle(6);
    chk("t1_strobe_count", scount - sbase, 4);
    chk("t1_level", int'(level), 4);
    seen_q.delete();
    run_line(4);
    chk("t1_seen_count", seen_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen_q.size()) chk("t1_pixel", int'(seen_q[i]), 16 + i);
    end
    chk("t1_underflow", int'(underflow), 0);

    // Fill to DEPTH with a 17th pixel waiting.
    sbase = scount;
    for (int i = 0; i < 17; i++) src_q.push_back(8'(8'h20 + i));
    idle(20);
    chk("t2_strobe_count", scount - sbase, 16);
    chk("t2_level_full", int'(level), 16);
    seen_q.delete();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("t2_level_refill", int'(level), 16);
    if (seen_q.size() > 0) chk("t2_first_pixel", int'(seen_q[0]), 32);
    drain();

    // Starved pops and underflow clearing.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t3_underflow_set", int'(underflow), 1);
    if (seen_q.size() > 0) chk("t3_black", int'(seen_q[$]), 0);
    tick(1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t3_underflow_clear", int'(underflow), 0);
    tick(1'b0, 1'b1, 1'b1);
    idle(1);
    chk("t3_set_wins", int'(underflow), 1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);

    // Line length limit: 6 buffered, 6 enables, only 4 emitted.
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h40 + i));
    idle(8);
    vbase = vcount;
    tick(1'b1, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t4_pulses", vcount - vbase, 4);
    chk("t4_level", int'(level), 2);
    vbase = vcount;
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t4_idle_no_valid", vcount - vbase, 0);
    drain();

    // Push into empty FIFO together with a pixel enable.
    tick(1'b1, 1'b0, 1'b0);
    src_q.push_back(8'h55);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t5_level", int'(level), 1);
    chk("t5_underflow", int'(underflow), 1);
    if (seen_q.size() > 0) chk("t5_black", int'(seen_q[$]), 0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    if (seen_q.size() > 0) chk("t5_pixel", int'(seen_q[$]), 85);
    chk("t5_level_after", int'(level), 0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    idle(2);

    // Reset mid-line with level 7 and a pixel in flight.
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h60 + i));
    idle(10);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    src_q.push_back(8'h99);
    tick(1'b0, 1'b0, 1'b0);
    chk("t6_level_pre", int'(level), 7);
    chk("t6_valid_pre", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_strobe", int'(in_strobe), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_pixel", int'(out_pixel), 0);
    chk("t6_rst_underflow", int'(underflow), 0);
    idle(2);
    reset = 1'b0;
    vbase = vcount;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("t6_no_valid_after_reset", vcount - vbase, 0);
    drain();

    // Random traffic against the model.
    rst_pending = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0 && src_q.size() < 4) src_q.push_back(8'($urandom));
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      if (rst_pending) begin
        reset = 1'b0;
        rst_pending = 1'b0;
      end else if ($urandom_range(0, 799) == 0) begin
        reset = 1'b1;
        rst_pending = 1'b1;
      end
    end
    reset = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
